ram_dma: RTL

//  Bus initiator for the 4 KiB RAM: fill and copy engine that drives address/select/rw/data toward the RAM.

---
 rtl/ram_bus_pkg.sv | 25 ++
 rtl/ram_dma_if.sv | 26 ++
 rtl/ram_dma.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// Shared constants and types for the RAM bus initiator: widths, op codes,
// bus direction encoding and the DMA state enum.
package ram_bus_pkg;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 13;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_COPY = 1'b1
    } op_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL_WR = 3'd1,
        ST_CP_RD   = 3'd2,
        ST_CP_CAP  = 3'd3,
        ST_CP_WR   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/ram_dma_if.sv
// RAM port bundle: the DMA engine drives it as master, the RAM answers as slave.
interface ram_dma_if #(
    parameter int ADDR_W = ram_bus_pkg::ADDR_W
);
    logic [ADDR_W-1:0] address;
    logic              select;
    logic              rw;
    logic [7:0]        dataOut;
    logic [7:0]        dataIn;

    modport master (
        output address,
        output select,
        output rw,
        output dataOut,
        input  dataIn
    );

    modport slave (
        input  address,
        input  select,
        input  rw,
        input  dataOut,
        output dataIn
    );
endinterface

// File: rtl/ram_dma.sv
// Fill/copy bus initiator for the 4 KiB RAM. Optional feature macro:
// RAM_DMA_CHECKSUM_EN adds an 8-bit modular sum of every byte written.
module ram_dma #(
    parameter int ADDR_W = ram_bus_pkg::ADDR_W,
    parameter int LEN_W  = ram_bus_pkg::LEN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        fillValue,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  remaining,
    ram_dma_if.master         bus
`ifdef RAM_DMA_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);
    import ram_bus_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_e            r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [7:0]        r_fill;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [ADDR_W-1:0] r_address;
    logic              r_select;
    logic              r_rw;
    logic [7:0]        r_data_out;

    logic [LEN_W-1:0]  w_len_sat;
    logic              w_last;

    assign w_len_sat = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_last    = (r_remaining == LEN_W'(1));

    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign remaining   = r_remaining;
    assign bus.address = r_address;
    assign bus.select  = r_select;
    assign bus.rw      = r_rw;
    assign bus.dataOut = r_data_out;

    // Transfer FSM; bus and status outputs are set on entry to each state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_fill      <= 8'h00;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_address   <= '0;
            r_select    <= 1'b0;
            r_rw        <= RW_READ;
            r_data_out  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src       <= srcAddr;
                        r_dst       <= dstAddr;
                        r_fill      <= fillValue;
                        r_remaining <= w_len_sat;
                        r_aborted   <= 1'b0;
                        if (w_len_sat == LEN_W'(0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (op == OP_COPY) begin
                            r_state   <= ST_CP_RD;
                            r_busy    <= 1'b1;
                            r_select  <= 1'b1;
                            r_rw      <= RW_READ;
                            r_address <= srcAddr;
                        end else begin
                            r_state    <= ST_FILL_WR;
                            r_busy     <= 1'b1;
                            r_select   <= 1'b1;
                            r_rw       <= RW_WRITE;
                            r_address  <= dstAddr;
                            r_data_out <= fillValue;
                        end
                    end
                end
                ST_FILL_WR: begin
                    r_dst       <= r_dst + ADDR_W'(1);
                    r_remaining <= r_remaining - LEN_W'(1);
                    if (abort || w_last) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= abort;
                        r_select  <= 1'b0;
                        r_rw      <= RW_READ;
                    end else begin
                        r_address <= r_dst + ADDR_W'(1);
                    end
                end
                ST_CP_RD: begin
                    r_select <= 1'b0;
                    r_rw     <= RW_READ;
                    if (abort) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= ST_CP_CAP;
                    end
                end
                ST_CP_CAP: begin
                    if (abort) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        // RAM read data is valid now; it becomes the byte to write
                        r_state    <= ST_CP_WR;
                        r_select   <= 1'b1;
                        r_rw       <= RW_WRITE;
                        r_address  <= r_dst;
                        r_data_out <= bus.dataIn;
                    end
                end
                ST_CP_WR: begin
                    r_src       <= r_src + ADDR_W'(1);
                    r_dst       <= r_dst + ADDR_W'(1);
                    r_remaining <= r_remaining - LEN_W'(1);
                    if (abort || w_last) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= abort;
                        r_select  <= 1'b0;
                        r_rw      <= RW_READ;
                    end else begin
                        r_state   <= ST_CP_RD;
                        r_select  <= 1'b1;
                        r_rw      <= RW_READ;
                        r_address <= r_src + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_select <= 1'b0;
                    r_rw     <= RW_READ;
                end
            endcase
        end
    end

`ifdef RAM_DMA_CHECKSUM_EN
    logic [7:0] r_checksum;

    assign checksum = r_checksum;

    // Running sum of bytes whose write completes on this edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= 8'h00;
        end else if (r_state == ST_IDLE && start) begin
            r_checksum <= 8'h00;
        end else if (r_select && r_rw == RW_WRITE) begin
            r_checksum <= r_checksum + r_data_out;
        end
    end
`endif

endmodule
